// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Round-robin arbiter that shares one i2c master between N_REQ requesters.
//   One transaction is in flight at a time:
//   1. Grant and latch the winner's address and write byte.
//   2. Pulse start to the master.
//   3. Wait for the master to go busy, then wait for it to go idle again.
//   4. Report completion to the winner.
//   Each wait phase is bounded by TIMEOUT cycles. Expiry completes the
//   transaction with ow_err=1.
//
// Ports
//   iw_clk, iw_reset   : clock, synchronous active-high reset
//   iw_req             : level request per requester
//   iw_addr, iw_wdata  : per-requester 7-bit address / 8-bit write byte slices
//   ow_gnt             : one-hot grant, held for the whole transaction
//   ow_done, ow_err    : one-cycle completion pulse to the winner, error flag
//   ow_rdata           : last byte captured from the master
//   ow_m_start         : one-cycle start strobe to the master
//   ow_m_addr          : address presented to the master
//   ow_m_wdata         : write byte presented to the master
//   ow_m_wdata_en      : drive enable for ow_m_wdata
//   iw_m_ready         : master idle
//   iw_m_data_en       : master read-data valid
//   iw_m_rdata         : master read data
//   ow_dbg_state       : current FSM state (IDLE=0 ... DONE=5)
//
// Handshake: a requester raises iw_req and keeps it high until it sees its
// ow_done bit. Grant only happens while the master reports ready. After
// ow_m_start the master is expected to drop iw_m_ready (busy) and raise it
// again when finished. Read data is accepted on any cycle of the finish wait
// where iw_m_data_en=1.

module i2c_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               iw_clk,
  input  logic               iw_reset,
  input  logic [N_REQ-1:0]   iw_req,
  input  logic [N_REQ*7-1:0] iw_addr,
  input  logic [N_REQ*8-1:0] iw_wdata,
  output logic [N_REQ-1:0]   ow_gnt,
  output logic [N_REQ-1:0]   ow_done,
  output logic               ow_err,
  output logic [7:0]         ow_rdata,
  output logic               ow_m_start,
  output logic [6:0]         ow_m_addr,
  output logic [7:0]         ow_m_wdata,
  output logic               ow_m_wdata_en,
  input  logic               iw_m_ready,
  input  logic               iw_m_data_en,
  input  logic [7:0]         iw_m_rdata,
  output logic [2:0]         ow_dbg_state
);

  localparam int            IW       = $clog2(N_REQ);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
  localparam logic [7:0]    TO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_last;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_err;
  logic [7:0]       r_rdata;
  logic             r_start;
  logic [6:0]       r_addr;
  logic [7:0]       r_wdata;
  logic             r_wdata_en;
  logic [7:0]       r_cnt;

  logic [IW-1:0]    w_cand;
  logic [IW-1:0]    w_win_idx;
  logic             w_win_found;
  logic [N_REQ-1:0] w_win_onehot;
  logic [6:0]       w_win_addr;
  logic [7:0]       w_win_wdata;
  logic             w_cnt_expired;

  // Round-robin search: scan the indices after r_last, wrapping through
  // r_last itself last, and take the first one that is requesting.
  always_comb begin
    w_cand      = '0;
    w_win_idx   = r_last;
    w_win_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IW'((int'(r_last) + k) % N_REQ);
      if (!w_win_found && iw_req[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;
    w_win_addr   = 7'(iw_addr >> (7 * w_win_idx));
    w_win_wdata  = 8'(iw_wdata >> (8 * w_win_idx));
  end

  // Each wait phase is allowed exactly TIMEOUT cycles. The counter is 0 in
  // the first cycle of a phase, so expiry is taken on the cycle whose
  // increment would bring it to TIMEOUT.
  assign w_cnt_expired = (r_cnt + 8'd1) == TO_LIMIT;

  always_ff @(posedge iw_clk) begin
    if (iw_reset) begin
      r_state    <= S_IDLE;
      r_last     <= LAST_RST;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_rdata    <= 8'h00;
      r_start    <= 1'b0;
      r_addr     <= 7'h00;
      r_wdata    <= 8'h00;
      r_wdata_en <= 1'b0;
      r_cnt      <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_found && iw_m_ready) begin
            r_state    <= S_ARB;
            r_gnt      <= w_win_onehot;
            r_last     <= w_win_idx;
            r_addr     <= w_win_addr;
            r_wdata    <= w_win_wdata;
            r_wdata_en <= 1'b1;
          end
        end
        S_ARB: begin
          r_state <= S_LAUNCH;
          r_start <= 1'b1;
        end
        S_LAUNCH: begin
          r_state    <= S_WAIT_BUSY;
          r_start    <= 1'b0;
          r_wdata_en <= 1'b0;
          r_cnt      <= 8'h00;
        end
        S_WAIT_BUSY: begin
          // The master going busy takes precedence over expiry in the same cycle.
          if (!iw_m_ready) begin
            r_state <= S_WAIT_DONE;
            r_cnt   <= 8'h00;
          end else if (w_cnt_expired) begin
            r_state <= S_DONE;
            r_done  <= r_gnt;
            r_err   <= 1'b1;
            r_cnt   <= r_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT_DONE: begin
          if (iw_m_data_en) begin
            r_rdata <= iw_m_rdata;
          end
          if (iw_m_ready) begin
            r_state <= S_DONE;
            r_done  <= r_gnt;
            r_err   <= 1'b0;
          end else if (w_cnt_expired) begin
            r_state <= S_DONE;
            r_done  <= r_gnt;
            r_err   <= 1'b1;
            r_cnt   <= r_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= '0;
          r_gnt   <= '0;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ow_gnt        = r_gnt;
  assign ow_done       = r_done;
  assign ow_err        = r_err;
  assign ow_rdata      = r_rdata;
  assign ow_m_start    = r_start;
  assign ow_m_addr     = r_addr;
  assign ow_m_wdata    = r_wdata;
  assign ow_m_wdata_en = r_wdata_en;
  assign ow_dbg_state  = r_state;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter.
// The bench has these parts:
//   - Clock and reset generation.
//   - A reactive master model.
//   - A transaction-level reference model, updated on each rising edge from
//     the inputs only.
//   - A per-cycle compare on the falling edge.
//   - Directed scenarios with hand-computed expectations.
//   - A final report.
module tb_i2c_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   req;
  logic [N*7-1:0] addr;
  logic [N*8-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           err;
  logic [7:0]     rdata;
  logic           m_start;
  logic [6:0]     m_addr;
  logic [7:0]     m_wdata;
  logic           m_wdata_en;
  logic           m_ready;
  logic           m_data_en;
  logic [7:0]     m_rdata;
  logic [2:0]     dbg_state;

  i2c_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .iw_clk        (clk),
    .iw_reset      (reset),
    .iw_req        (req),
    .iw_addr       (addr),
    .iw_wdata      (wdata),
    .ow_gnt        (gnt),
    .ow_done       (done),
    .ow_err        (err),
    .ow_rdata      (rdata),
    .ow_m_start    (m_start),
    .ow_m_addr     (m_addr),
    .ow_m_wdata    (m_wdata),
    .ow_m_wdata_en (m_wdata_en),
    .iw_m_ready    (m_ready),
    .iw_m_data_en  (m_data_en),
    .iw_m_rdata    (m_rdata),
    .ow_dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit         md_valid = 1'b0;
  bit         md_active, md_report, md_err, md_busy_seen;
  int         md_idx, md_last, md_age, md_wait;
  logic [7:0] md_rdata;
  logic [6:0] md_addr;
  logic [7:0] md_wdata;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int rv;
    int pos;
    int win;
    bit found;
    rv    = int'(r);
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos = (last + k) % N;
      if (!found && (((rv >> pos) & 1) != 0)) begin
        found = 1'b1;
        win   = pos;
      end
    end
    return win;
  endfunction

  task automatic model_step();
    logic [N*7-1:0] at;
    logic [N*8-1:0] wt;
    if (reset) begin
      md_valid  = 1'b1;
      md_active = 1'b0;
      md_report = 1'b0;
      md_err    = 1'b0;
      md_last   = N - 1;
      md_idx    = 0;
      md_rdata  = 8'h00;
      md_addr   = 7'h00;
      md_wdata  = 8'h00;
    end else if (md_valid) begin
      if (md_report) begin
        md_active = 1'b0;
        md_report = 1'b0;
        md_err    = 1'b0;
      end else if (!md_active) begin
        if (req != '0 && m_ready) begin
          md_idx       = rr_pick(req, md_last);
          md_last      = md_idx;
          md_active    = 1'b1;
          md_age       = 0;
          md_wait      = 0;
          md_busy_seen = 1'b0;
          at = addr >> (md_idx * 7);
          wt = wdata >> (md_idx * 8);
          md_addr  = at[6:0];
          md_wdata = wt[7:0];
        end
      end else if (md_age < 2) begin
        md_age++;
        md_wait = 0;
      end else if (!md_busy_seen) begin
        if (!m_ready) begin
          md_busy_seen = 1'b1;
          md_wait      = 0;
        end else if (md_wait + 1 == TO) begin
          md_report = 1'b1;
          md_err    = 1'b1;
        end else begin
          md_wait++;
        end
      end else begin
        if (m_data_en) md_rdata = m_rdata;
        if (m_ready) begin
          md_report = 1'b1;
          md_err    = 1'b0;
        end else if (md_wait + 1 == TO) begin
          md_report = 1'b1;
          md_err    = 1'b1;
        end else begin
          md_wait++;
        end
      end
    end
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare_proc
    logic [N-1:0] oh;
    logic [33:0]  act_v;
    logic [33:0]  exp_v;
    forever begin
      @(negedge clk);
      if (md_valid) begin
        oh = '0;
        if (md_active) oh = {{(N-1){1'b0}}, 1'b1} << md_idx;
        exp_v = {oh,
                 md_report ? oh : {N{1'b0}},
                 md_report & md_err,
                 md_rdata,
                 md_active && !md_report && md_age == 1,
                 md_addr,
                 md_wdata,
                 md_active && !md_report && md_age <= 1};
        act_v = {gnt, done, err, rdata, m_start, m_addr, m_wdata, m_wdata_en};
        check("cycle", 64'(act_v), 64'(exp_v));
      end
    end
  end

  // ---------------- master model ----------------
  bit         ms_hang = 1'b0;
  bit         ms_rd   = 1'b0;
  int         ms_busy_len = 3;
  logic [7:0] ms_rd_val = 8'h00;

  initial begin : master_proc
    m_ready   = 1'b1;
    m_data_en = 1'b0;
    m_rdata   = 8'h00;
    forever begin
      @(negedge clk);
      if (m_start && !ms_hang) begin
        m_ready = 1'b0;
        for (int j = 1; j <= ms_busy_len; j++) begin
          @(negedge clk);
          if (ms_rd && j == ms_busy_len - 1) begin
            m_data_en = 1'b1;
            m_rdata   = ms_rd_val;
          end else begin
            m_data_en = 1'b0;
            m_rdata   = 8'hEE;
          end
        end
        m_ready   = 1'b1;
        m_data_en = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_start(output int t);
    bit ok;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (m_start) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
    check("start_seen", 64'(ok), 64'(1));
  endtask

  task automatic wait_done(output int t, output logic [N-1:0] d, output logic e);
    bit ok;
    ok = 1'b0;
    t  = 0;
    d  = '0;
    e  = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (done != '0) begin
        ok = 1'b1;
        t  = cyc;
        d  = done;
        e  = err;
      end
    end
    check("done_seen", 64'(ok), 64'(1));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main_proc
    int           t_req;
    int           t_s;
    int           t_d;
    logic [N-1:0] d;
    logic         e;
    int           rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    req   = '0;
    addr  = {7'h13, 7'h42, 7'h21, 7'h10};
    wdata = {8'h5A, 8'hA5, 8'h77, 8'h11};
    repeat (3) @(negedge clk);
    check("rst_gnt_done", 64'({gnt, done}), 64'(0));
    check("rst_master_side", 64'({err, rdata, m_start, m_addr, m_wdata, m_wdata_en}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    reset = 1'b0;

    // Single request from index 2
    @(negedge clk);
    req   = 4'b0100;
    t_req = cyc;
    wait_start(t_s);
    check("single_latency", 64'(t_s - t_req), 64'(2));
    check("single_gnt", 64'(gnt), 64'(4'b0100));
    check("single_addr", 64'(m_addr), 64'(7'h42));
    check("single_wdata", 64'(m_wdata), 64'(8'hA5));
    wait_done(t_d, d, e);
    check("single_done", 64'(d), 64'(4'b0100));
    check("single_err", 64'(e), 64'(0));
    req = '0;

    // Round robin from the reset pointer
    @(negedge clk);
    pulse_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_start(t_s);
      check("rr_gnt", 64'(gnt), 64'(4'b0001 << rr_exp[g]));
      wait_done(t_d, d, e);
      check("rr_done", 64'(d), 64'(4'b0001 << rr_exp[g]));
    end
    req = '0;

    // Timeout: master never goes busy
    @(negedge clk);
    ms_hang = 1'b1;
    req     = 4'b0010;
    wait_start(t_s);
    wait_done(t_d, d, e);
    check("to_cycles", 64'(t_d - t_s), 64'(9));
    check("to_done", 64'(d), 64'(4'b0010));
    check("to_err", 64'(e), 64'(1));
    req     = '0;
    ms_hang = 1'b0;

    // Read capture
    @(negedge clk);
    ms_rd       = 1'b1;
    ms_rd_val   = 8'h3C;
    ms_busy_len = 4;
    req         = 4'b1000;
    wait_start(t_s);
    check("rd_gnt", 64'({gnt, m_addr, m_wdata}), 64'({4'b1000, 7'h13, 8'h5A}));
    wait_done(t_d, d, e);
    check("rd_done", 64'({d, e}), 64'({4'b1000, 1'b0}));
    check("rd_data", 64'(rdata), 64'(8'h3C));
    req   = '0;
    ms_rd = 1'b0;
    repeat (3) @(negedge clk);
    check("rd_hold", 64'(rdata), 64'(8'h3C));

    // Request dropped mid-transaction
    ms_busy_len = 5;
    req         = 4'b0001;
    wait_start(t_s);
    @(negedge clk);
    req = '0;
    wait_done(t_d, d, e);
    check("drop_done", 64'({d, e}), 64'({4'b0001, 1'b0}));

    // Reset in the finish wait
    @(negedge clk);
    ms_busy_len = 6;
    req         = 4'b0100;
    wait_start(t_s);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    check("midrst_outputs", 64'({gnt, done, err, rdata, m_start, m_addr, m_wdata, m_wdata_en}), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(0));
    reset = 1'b0;
    req   = 4'b1001;
    @(negedge clk);
    check("midrst_no_gnt_busy", 64'(gnt), 64'(0));
    @(negedge clk);
    check("midrst_no_gnt_busy", 64'(gnt), 64'(0));
    wait_start(t_s);
    check("midrst_first_gnt", 64'(gnt), 64'(4'b0001));
    wait_done(t_d, d, e);
    check("midrst_done", 64'({d, e}), 64'({4'b0001, 1'b0}));
    req = '0;

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
